// File: rtl/bitlet_distiller.sv
// -----------------------------------------------------------------------------
// bitlet_distiller
//
// Purpose:
//   Takes N (weight mantissa, weight sign, activation) pairs and turns them
//   into a stream of 24-element operand vectors for a bit-serial adder tree.
//   Every beat, each of the 24 mantissa bit columns independently picks the
//   lowest-indexed pair that still has a 1 in that column. The column emits
//   that pair's activation, or its negation when the weight is negative. The
//   chosen bit is then consumed. The load finishes when no set bits remain.
//
// Ports:
//   clk      in   single clock, rising edge
//   rst      in   asynchronous active-high reset
//   LD_vld   in   load request
//   LD_rdy   out  load accept (high only while IDLE, combinational)
//   LD_wmag  in   N x 24-bit weight mantissa magnitudes, pair j at [j*24+:24]
//   LD_wsgn  in   N weight signs, 1 = negative
//   LD_act   in   N x WID_FIX signed activations, pair j at [j*WID_FIX+:WID_FIX]
//   DO_vld   out  output beat valid (consumer never stalls)
//   DO_vec   out  24 x WID_FIX operands, element i = bit significance i
//   DO_last  out  final beat of the current load
// -----------------------------------------------------------------------------
module bitlet_distiller #(
    parameter int N       = 8,
    parameter int WID_FIX = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    LD_vld,
    output logic                    LD_rdy,
    input  logic [N*24-1:0]         LD_wmag,
    input  logic [N-1:0]            LD_wsgn,
    input  logic [N*WID_FIX-1:0]    LD_act,
    output logic                    DO_vld,
    output logic [24*WID_FIX-1:0]   DO_vec,
    output logic                    DO_last
);

    localparam int COLS  = 24;
    // One spare bit so that a runaway count above N cannot wrap and hide.
    localparam int CNT_W = $clog2(N + 1) + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;

    logic [N*24-1:0]            r_mask;
    logic [N-1:0]               r_sgn;
    logic [N*WID_FIX-1:0]       r_act;
    logic [CNT_W-1:0]           r_beat_cnt;

    logic                       r_do_vld;
    logic [COLS*WID_FIX-1:0]    r_do_vec;
    logic                       r_do_last;

    logic [N*24-1:0]            w_mask_next;
    logic [COLS*WID_FIX-1:0]    w_vec;
    logic [COLS-1:0]            w_col_hit;
    logic                       w_mask_done;
    logic                       w_accept;

    assign LD_rdy   = (r_state == S_IDLE);
    assign w_accept = LD_vld && LD_rdy;

    assign DO_vld   = r_do_vld;
    assign DO_vec   = r_do_vec;
    assign DO_last  = r_do_last;

    // -------------------------------------------------------------------------
    // Column selection: per column, a priority pick of the lowest set row.
    // w_col_hit marks columns that have already found their row, so only the
    // first hit in each column produces an operand and clears its mask bit.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before the loops,
        // so no path leaves a signal unassigned and no latch is inferred.
        w_vec       = '0;
        w_mask_next = r_mask;
        w_col_hit   = '0;
        for (int i = 0; i < COLS; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!w_col_hit[i] && r_mask[j*24 + i]) begin
                    w_col_hit[i]         = 1'b1;
                    w_mask_next[j*24 + i] = 1'b0;
                    // Negation wraps modulo 2^WID_FIX, so the most negative
                    // activation maps to itself.
                    w_vec[i*WID_FIX +: WID_FIX] = r_sgn[j]
                        ? -r_act[j*WID_FIX +: WID_FIX]
                        :  r_act[j*WID_FIX +: WID_FIX];
                end
            end
        end
    end

    // The beat just computed is the final one when nothing is left afterwards.
    assign w_mask_done = (w_mask_next == '0);

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)    w_state_next = S_RUN;
            S_RUN:   if (w_mask_done) w_state_next = S_IDLE;
            default:                  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments, so every
            // flop samples pre-edge values regardless of statement order.
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Working registers and the registered output beat
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the working mask is reset as well as the control state.
            // An abort must leave no stale bits that a later load could see.
            r_mask     <= '0;
            r_sgn      <= '0;
            r_act      <= '0;
            r_beat_cnt <= '0;
            r_do_vld   <= 1'b0;
            r_do_vec   <= '0;
            r_do_last  <= 1'b0;
        end else begin
            if (r_state == S_RUN) begin
                r_mask     <= w_mask_next;
                r_beat_cnt <= r_beat_cnt + 1'b1;
                r_do_vld   <= 1'b1;
                r_do_vec   <= w_vec;
                r_do_last  <= w_mask_done;
            end else begin
                // An idle cycle always presents a zero, non-last, invalid beat.
                r_do_vld  <= 1'b0;
                r_do_vec  <= '0;
                r_do_last <= 1'b0;
                if (w_accept) begin
                    r_mask     <= LD_wmag;
                    r_sgn      <= LD_wsgn;
                    r_act      <= LD_act;
                    r_beat_cnt <= '0;
                end
            end
        end
    end

    // Each beat clears at least one bit per non-empty column, and no column
    // holds more than N bits, so a load never runs longer than N beats.
    a_beat_bound : assert property (@(posedge clk) disable iff (rst)
        r_beat_cnt <= CNT_W'(N));

endmodule

// File: tb/tb_bitlet_distiller.sv
// -----------------------------------------------------------------------------
// tb_bitlet_distiller
//
// Drives directed and randomized loads into bitlet_distiller (N=8,
// WID_FIX=16). Expected beats come from a reference model: beat k of column i
// carries the signed operand of the k-th set bit, counted from row 0 upward.
// -----------------------------------------------------------------------------
module tb_bitlet_distiller;

    localparam int N   = 8;
    localparam int W   = 16;
    localparam int VEC = 24 * W;

    logic              clk;
    logic              rst;
    logic              LD_vld;
    logic              LD_rdy;
    logic [N*24-1:0]   LD_wmag;
    logic [N-1:0]      LD_wsgn;
    logic [N*W-1:0]    LD_act;
    logic              DO_vld;
    logic [VEC-1:0]    DO_vec;
    logic              DO_last;

    bitlet_distiller #(.N(N), .WID_FIX(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .LD_vld  (LD_vld),
        .LD_rdy  (LD_rdy),
        .LD_wmag (LD_wmag),
        .LD_wsgn (LD_wsgn),
        .LD_act  (LD_act),
        .DO_vld  (DO_vld),
        .DO_vec  (DO_vec),
        .DO_last (DO_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int             n_checks = 0;
    int             n_errors = 0;

    // Reference model output
    logic [VEC-1:0] exp_beats [N];
    int             exp_n;

    task automatic check(input string tag, input logic [VEC-1:0] obs,
                         input logic [VEC-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Beat k, column i = value of the k-th pair (lowest row first) whose
    // weight has bit i set. The beat count is the tallest column, minimum 1.
    task automatic build_model(input logic [N*24-1:0] wmag,
                               input logic [N-1:0] wsgn,
                               input logic [N*W-1:0] act);
        int rank;
        int a;
        int v;
        for (int k = 0; k < N; k++) exp_beats[k] = '0;
        exp_n = 1;
        for (int i = 0; i < 24; i++) begin
            rank = 0;
            for (int j = 0; j < N; j++) begin
                if (wmag[j*24 + i]) begin
                    a = int'($signed(act[j*W +: W]));
                    v = wsgn[j] ? (0 - a) : a;
                    exp_beats[rank][i*W +: W] = v[W-1:0];
                    rank++;
                end
            end
            if (rank > exp_n) exp_n = rank;
        end
    endtask

    // Presents a load and checks every beat of it, up to stop_k beats.
    // The task returns at posedge+1 of the last observed beat. With hold set,
    // LD_vld stays high through RUN while the load data changes underneath.
    task automatic run_load(input string name, input logic [N*24-1:0] wmag,
                            input logic [N-1:0] wsgn, input logic [N*W-1:0] act,
                            input bit hold, input int stop_k);
        int last_k;
        build_model(wmag, wsgn, act);
        LD_wmag = wmag;
        LD_wsgn = wsgn;
        LD_act  = act;
        LD_vld  = 1'b1;
        check({name, ":rdy_pre"}, VEC'(LD_rdy), VEC'(1'b1));
        @(posedge clk); #1;
        if (hold) begin
            for (int j = 0; j < N; j++) LD_wmag[j*24 +: 24] = 24'($urandom);
            LD_act  = {4{$urandom}};
            LD_wsgn = 8'($urandom);
        end else begin
            LD_vld = 1'b0;
        end
        check({name, ":rdy_run"}, VEC'(LD_rdy), VEC'(1'b0));
        check({name, ":gap"}, VEC'(DO_vld), VEC'(1'b0));
        last_k = (stop_k < exp_n) ? stop_k : exp_n;
        for (int k = 0; k < last_k; k++) begin
            @(posedge clk); #1;
            check($sformatf("%s:vld%0d", name, k), VEC'(DO_vld), VEC'(1'b1));
            check($sformatf("%s:vec%0d", name, k), DO_vec, exp_beats[k]);
            check($sformatf("%s:last%0d", name, k), VEC'(DO_last),
                  VEC'(k == exp_n - 1));
            check($sformatf("%s:rdy%0d", name, k), VEC'(LD_rdy),
                  VEC'(k == exp_n - 1));
            if (k == exp_n - 1) LD_vld = 1'b0;
        end
    endtask

    task automatic idle_check(input string name);
        @(posedge clk); #1;
        check({name, ":idle_vld"}, VEC'(DO_vld), VEC'(1'b0));
        check({name, ":idle_vec"}, DO_vec, '0);
        check({name, ":idle_last"}, VEC'(DO_last), VEC'(1'b0));
        check({name, ":idle_rdy"}, VEC'(LD_rdy), VEC'(1'b1));
    endtask

    logic [N*24-1:0] single_wmag, coll_wmag, full_wmag, rnd_wmag;
    logic [N*W-1:0]  single_act, coll_act, seq_act, min_act, rnd_act;
    logic [N-1:0]    rnd_sgn;

    initial begin
        // Directed vectors
        single_wmag = '0; single_wmag[23:0] = 24'h000005;
        single_act  = '0; single_act[15:0]  = 16'd3;
        coll_wmag   = '0;
        coll_act    = '0;
        for (int j = 0; j < 3; j++) begin
            coll_wmag[j*24 +: 24] = 24'h000001;
            coll_act[j*W +: W]    = W'(10 * (j + 1));
        end
        for (int j = 0; j < N; j++) begin
            full_wmag[j*24 +: 24] = 24'hFFFFFF;
            seq_act[j*W +: W]     = W'(j + 1);
        end
        min_act = '0; min_act[15:0] = 16'h8000;

        // Reset
        rst     = 1'b1;
        LD_vld  = 1'b0;
        LD_wmag = '0;
        LD_wsgn = '0;
        LD_act  = '0;
        #12;
        check("reset:vld", VEC'(DO_vld), VEC'(1'b0));
        check("reset:vec", DO_vec, '0);
        check("reset:last", VEC'(DO_last), VEC'(1'b0));
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset:rdy", VEC'(LD_rdy), VEC'(1'b1));

        // Single pair: one beat, elements 0 and 2
        run_load("single", single_wmag, 8'h00, single_act, 1'b0, N);
        idle_check("single");

        // Column collision with a negative middle weight
        run_load("collide", coll_wmag, 8'b0000_0010, coll_act, 1'b0, N);
        idle_check("collide");

        // All-zero weights still produce one last beat
        run_load("zero", '0, 8'hFF, seq_act, 1'b0, N);
        idle_check("zero");

        // Full weights with LD_vld held high during RUN
        run_load("full", full_wmag, 8'h00, seq_act, 1'b1, N);
        idle_check("full");

        // Negating the most negative activation wraps to itself
        run_load("minneg", single_wmag, 8'h01, min_act, 1'b0, N);
        idle_check("minneg");

        // Back-to-back: next load accepted in the DO_last cycle
        run_load("b2b_a", coll_wmag, 8'b0000_0010, coll_act, 1'b0, N);
        run_load("b2b_b", single_wmag, 8'h00, single_act, 1'b0, N);
        idle_check("b2b");

        // Abort a full load during its third beat
        run_load("abort", full_wmag, 8'h00, seq_act, 1'b1, 3);
        #2;
        rst    = 1'b1;
        LD_vld = 1'b0;
        #1;
        check("abort:vld", VEC'(DO_vld), VEC'(1'b0));
        check("abort:vec", DO_vec, '0);
        check("abort:last", VEC'(DO_last), VEC'(1'b0));
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort:rdy", VEC'(LD_rdy), VEC'(1'b1));
        check("abort:quiet", VEC'(DO_vld), VEC'(1'b0));
        run_load("post_abort", single_wmag, 8'h00, single_act, 1'b0, N);
        idle_check("post_abort");

        // Randomized loads, sometimes back-to-back
        for (int t = 0; t < 30; t++) begin
            for (int j = 0; j < N; j++)
                rnd_wmag[j*24 +: 24] = 24'($urandom & $urandom);
            if ($urandom_range(0, 5) == 0) rnd_wmag = '0;
            rnd_act = {4{$urandom}};
            if ($urandom_range(0, 3) == 0) rnd_act[W-1:0] = 16'h8000;
            rnd_sgn = 8'($urandom);
            run_load($sformatf("rnd%0d", t), rnd_wmag, rnd_sgn, rnd_act,
                     1'($urandom_range(0, 1)), N);
            if ($urandom_range(0, 1) == 1) idle_check($sformatf("rnd%0d", t));
        end
        idle_check("end");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
